// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the multicycle RV32I core: ALU operation codes
// (encoded as {funct7[5], funct3}), the major opcodes the core executes, and a
// packed view of the R/I-type instruction layout used for field decoding.
// Imported by the datapath, the ALU and the control unit.
// -----------------------------------------------------------------------------
package rv_pkg;

    // ALU operation codes: {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Major opcodes
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // R/I-type field layout (I-type immediate overlays funct7/rs2)
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } ir_fields_t;

endpackage : rv_pkg

// File: rtl/rv_alu.sv
// -----------------------------------------------------------------------------
// rv_alu
// Combinational RV32I integer ALU.
// Ports:
//   src1_i    [XLEN-1:0]  first operand
//   src2_i    [XLEN-1:0]  second operand (shifts use src2_i[4:0] only)
//   alu_op_i  [3:0]       {funct7[5], funct3} operation code
//   result_o  [XLEN-1:0]  result; unknown codes produce 0
// -----------------------------------------------------------------------------
module rv_alu
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [3:0]      alu_op_i,
    output logic [XLEN-1:0] result_o
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] sra_res;
    logic            lt_signed;
    logic            lt_unsigned;

    assign shamt       = src2_i[4:0];
    assign sra_res     = $signed(src1_i) >>> shamt;
    assign lt_signed   = $signed(src1_i) < $signed(src2_i);
    assign lt_unsigned = src1_i < src2_i;

    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_ADD:  result_o = src1_i + src2_i;
            ALU_SUB:  result_o = src1_i - src2_i;
            ALU_SLL:  result_o = src1_i << shamt;
            ALU_SRL:  result_o = src1_i >> shamt;
            ALU_SRA:  result_o = sra_res;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_XOR:  result_o = src1_i ^ src2_i;
            ALU_OR:   result_o = src1_i | src2_i;
            ALU_AND:  result_o = src1_i & src2_i;
            default:  result_o = '0;
        endcase
    end

endmodule : rv_alu

// File: rtl/rv_mc_datapath.sv
// -----------------------------------------------------------------------------
// rv_mc_datapath
// Multicycle RV32I datapath (R-type ALU, I-type ALU, LUI). Holds PC, IR, a
// 32x32 register file, the A/B operand latches and the F result latch. Driven
// by per-state strobes from the control unit; returns decoded IR fields.
//
// Handshake: there is none. Every strobe is a level sampled at the rising edge
// that ends the cycle in which it is high; the control unit holds each strobe
// stable for the whole state.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   PC_Write                  PC <= PC + 4
//   IR_Write                  IR <= inst_data (fetched from the current PC)
//   Reg_Write                 regfile[rd] <= write data
//   rs2_imm_s                 ALU src2: 0 = B latch, 1 = I-immediate
//   w_data_s                  write data: 0 = F latch, 1 = U-immediate
//   ALU_OP   [3:0]            {funct7[5], funct3}
//   inst_addr [IMEM_AW-1:0]   ROM word address (combinational from PC)
//   inst_data [31:0]          ROM read data, same cycle
//   opcode/funct3/funct7      IR fields
//   alu_zf                    registered (F == 0)
//   dbg_pc, dbg_f             current PC and F latch
// -----------------------------------------------------------------------------
module rv_mc_datapath
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PC_Write,
    input  logic               IR_Write,
    input  logic               Reg_Write,
    input  logic               rs2_imm_s,
    input  logic               w_data_s,
    input  logic [3:0]         ALU_OP,
    output logic [IMEM_AW-1:0] inst_addr,
    input  logic [31:0]        inst_data,
    output logic [6:0]         opcode,
    output logic [2:0]         funct3,
    output logic [6:0]         funct7,
    output logic               alu_zf,
    output logic [XLEN-1:0]    dbg_pc,
    output logic [XLEN-1:0]    dbg_f
);

    // ---------------------------------------------------------------- state
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] f_q, f_d;
    logic            zf_q, zf_d;
    logic [XLEN-1:0] rf_q [32];

    // ---------------------------------------------------------------- decode
    ir_fields_t      ir_f;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] alu_src2;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] wdata;

    assign ir_f  = ir_fields_t'(ir_q);
    assign imm_i = XLEN'($signed(ir_q[31:20]));
    assign imm_u = XLEN'($signed({ir_q[31:12], 12'b0}));

    // x0 is hardwired: mask the read rather than relying on the stored word
    assign rs1_val = (ir_f.rs1 == 5'd0) ? '0 : rf_q[ir_f.rs1];
    assign rs2_val = (ir_f.rs2 == 5'd0) ? '0 : rf_q[ir_f.rs2];

    assign alu_src2 = rs2_imm_s ? imm_i : b_q;
    assign wdata    = w_data_s ? imm_u : f_q;

    rv_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .src1_i  (a_q),
        .src2_i  (alu_src2),
        .alu_op_i(ALU_OP),
        .result_o(alu_res)
    );

    // ---------------------------------------------------------------- next state
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        if (PC_Write) begin
            pc_d = pc_q + XLEN'(4);
        end
        if (IR_Write) begin
            ir_d = inst_data;
        end
        // Operand and result latches load unconditionally every edge; the
        // control sequence guarantees they hold the right value when used.
        a_d  = rs1_val;
        b_d  = rs2_val;
        f_d  = alu_res;
        zf_d = (alu_res == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            ir_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            f_q  <= '0;
            zf_q <= 1'b1;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            a_q  <= a_d;
            b_q  <= b_d;
            f_q  <= f_d;
            zf_q <= zf_d;
        end
    end

    // Register file: A/B sample with the same edge as a write, so a
    // read-during-write captures the old value (no bypass).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (Reg_Write && (ir_f.rd != 5'd0)) begin
            rf_q[ir_f.rd] <= wdata;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign inst_addr = pc_q[IMEM_AW+1:2];
    assign opcode    = ir_f.opcode;
    assign funct3    = ir_f.funct3;
    assign funct7    = ir_f.funct7;
    assign alu_zf    = zf_q;
    assign dbg_pc    = pc_q;
    assign dbg_f     = f_q;

endmodule : rv_mc_datapath

// File: tb/tb_rv_mc_datapath.sv
// -----------------------------------------------------------------------------
// tb_rv_mc_datapath
// The bench plays the control unit and the instruction ROM. Each instruction
// runs fetch / decode / execute / write-back; an ISA-level register model
// predicts the F value of every execute and the PC after every fetch.
// RESET_PC is placed two words below 2^32 so the PC wrap happens early.
// -----------------------------------------------------------------------------
module tb_rv_mc_datapath;
    import rv_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    // ---------------------------------------------------------------- clock/reset
    logic        clk = 1'b0;
    logic        rst_n;
    logic        PC_Write, IR_Write, Reg_Write, rs2_imm_s, w_data_s;
    logic [3:0]  ALU_OP;
    logic [5:0]  inst_addr;
    logic [31:0] inst_data;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_zf;
    logic [31:0] dbg_pc, dbg_f;

    always #5 clk = ~clk;

    logic [31:0] rom [64];
    assign inst_data = rom[inst_addr];

    rv_mc_datapath #(
        .XLEN(32),
        .RESET_PC(RST_PC),
        .IMEM_AW(6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PC_Write (PC_Write),
        .IR_Write (IR_Write),
        .Reg_Write(Reg_Write),
        .rs2_imm_s(rs2_imm_s),
        .w_data_s (w_data_s),
        .ALU_OP   (ALU_OP),
        .inst_addr(inst_addr),
        .inst_data(inst_data),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_zf   (alu_zf),
        .dbg_pc   (dbg_pc),
        .dbg_f    (dbg_f)
    );

    // ---------------------------------------------------------------- scoreboard
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, OP_IMM};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_REG};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, OP_LUI};
    endfunction

    // ---------------------------------------------------------------- driver
    task automatic cycle(input logic pcw, input logic irw, input logic rw,
                         input logic imm_s, input logic wds, input logic [3:0] op);
        PC_Write  = pcw;
        IR_Write  = irw;
        Reg_Write = rw;
        rs2_imm_s = imm_s;
        w_data_s  = wds;
        ALU_OP    = op;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = RST_PC;
    endtask

    // One full instruction: fetch, decode, execute, write-back.
    task automatic run_instr(input logic [31:0] instr, output logic [31:0] f_obs);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic        imm_s;
        logic [3:0]  op;
        logic [31:0] src2, exp_f, wd;
        opc = instr[6:0];
        f3  = instr[14:12];
        rd  = instr[11:7];
        rs1 = instr[19:15];
        rs2 = instr[24:20];

        rom[m_pc[7:2]] = instr;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        m_pc = m_pc + 32'd4;
        check("opcode", {25'd0, opcode}, {25'd0, opc});
        check("funct3", {29'd0, funct3}, {29'd0, f3});
        check("funct7", {25'd0, funct7}, {25'd0, instr[31:25]});
        check("pc", dbg_pc, m_pc);

        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        imm_s = (opc == OP_IMM);
        if (imm_s) op = {(f3 == 3'b101) ? instr[30] : 1'b0, f3};
        else       op = {instr[30], f3};
        src2  = imm_s ? {{20{instr[31]}}, instr[31:20]} : m_regs[rs2];
        exp_f = alu_ref(op, m_regs[rs1], src2);
        exp_q.push_back(exp_f);
        cycle(1'b0, 1'b0, 1'b0, imm_s, 1'b0, op);
        f_obs = dbg_f;
        exp_f = exp_q.pop_front();
        if (opc != OP_LUI) begin
            check("alu_f", dbg_f, exp_f);
            check("alu_zf", {31'd0, alu_zf}, {31'd0, (exp_f == 32'd0)});
        end

        wd = (opc == OP_LUI) ? {instr[31:12], 12'd0} : exp_f;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, (opc == OP_LUI), 4'h0);
        if (rd != 5'd0) m_regs[rd] = wd;
    endtask

    task automatic read_reg(input logic [4:0] n, output logic [31:0] val);
        run_instr(enc_i(12'd0, n, 3'b000, 5'd0), val);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] f;
        logic [31:0] ins;
        logic [2:0]  f3;
        logic [11:0] imm;

        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        check("rst_pc", dbg_pc, RST_PC);
        check("rst_opcode", {25'd0, opcode}, 32'd0);
        check("rst_f", dbg_f, 32'd0);
        check("rst_zf", {31'd0, alu_zf}, 32'd1);
        rst_n = 1'b1;
        model_reset();

        // ADDI x1,x0,5 ; ADDI x2,x0,7 (second fetch wraps the PC)
        run_instr(32'h0050_0093, f);
        check("addi_x1", f, 32'd5);
        run_instr(enc_i(12'd7, 5'd0, 3'b000, 5'd2), f);
        check("pc_wrap", dbg_pc, 32'd0);

        // SUB x3,x1,x2 ; SRAI x4,x3,1 ; SRLI x7,x3,1 ; SRA x12 via register
        run_instr(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), f);
        check("sub", f, 32'hFFFF_FFFE);
        run_instr(enc_i(12'h401, 5'd3, 3'b101, 5'd4), f);
        check("srai", f, 32'hFFFF_FFFF);
        run_instr(enc_i(12'h001, 5'd3, 3'b101, 5'd7), f);
        check("srli", f, 32'h7FFF_FFFF);
        run_instr(enc_r(7'b0100000, 5'd1, 5'd3, 3'b101, 5'd12), f);
        check("sra_reg", f, 32'hFFFF_FFFF);

        // LUI x5,0x12345
        run_instr(enc_u(20'h12345, 5'd5), f);
        read_reg(5'd5, f);
        check("lui", f, 32'h1234_5000);

        // x0 write is discarded
        run_instr(enc_i(12'd9, 5'd0, 3'b000, 5'd0), f);
        read_reg(5'd0, f);
        check("x0", f, 32'd0);

        // SLT / SLTU with -1 vs 1
        run_instr(enc_i(12'hFFF, 5'd0, 3'b000, 5'd8), f);
        run_instr(enc_i(12'd1, 5'd0, 3'b000, 5'd9), f);
        run_instr(enc_r(7'd0, 5'd9, 5'd8, 3'b010, 5'd10), f);
        check("slt", f, 32'd1);
        run_instr(enc_r(7'd0, 5'd9, 5'd8, 3'b011, 5'd11), f);
        check("sltu", f, 32'd0);
        check("sltu_zf", {31'd0, alu_zf}, 32'd1);

        // Read-during-write: ADDI x6,x6,3 with x6=10. A sampled at the
        // write-back edge still holds 10; one edge later it holds 13.
        run_instr(enc_i(12'd10, 5'd0, 3'b000, 5'd6), f);
        run_instr(enc_i(12'd3, 5'd6, 3'b000, 5'd6), f);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
        check("rdw_old", dbg_f, 32'd13);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
        check("rdw_new", dbg_f, 32'd16);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: ins = enc_r($urandom_range(0, 1) ? 7'b0100000 : 7'b0000000,
                               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                               f3, 5'($urandom_range(0, 31)));
                1: begin
                    imm = 12'($urandom);
                    if (f3 == 3'b001) imm = {7'd0, imm[4:0]};
                    if (f3 == 3'b101) imm = {1'b0, imm[10], 5'd0, imm[4:0]};
                    ins = enc_i(imm, 5'($urandom_range(0, 31)), f3,
                                5'($urandom_range(0, 31)));
                end
                default: ins = enc_u(20'($urandom), 5'($urandom_range(0, 31)));
            endcase
            run_instr(ins, f);
        end

        // Reset mid-instruction: fetch and decode, then assert reset between edges
        rom[m_pc[7:2]] = enc_i(12'd1, 5'd5, 3'b000, 5'd13);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pc", dbg_pc, RST_PC);
        check("mid_rst_opcode", {25'd0, opcode}, 32'd0);
        check("mid_rst_f", dbg_f, 32'd0);
        check("mid_rst_zf", {31'd0, alu_zf}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        read_reg(5'd5, f);
        check("x5_after_rst", f, 32'd0);
        read_reg(5'd1, f);
        check("x1_after_rst", f, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rv_mc_datapath
